// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and load/store.
// One transaction in flight at a time; data has priority, bounded by a fetch starvation counter.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            f_req_i,
    input  logic [AW-1:0]   f_addr_i,
    output logic            f_gnt_o,
    output logic            f_rvalid_o,
    output logic [DW-1:0]   f_rdata_o,
    input  logic            d_req_i,
    input  logic            d_we_i,
    input  logic [DW/8-1:0] d_be_i,
    input  logic [AW-1:0]   d_addr_i,
    input  logic [DW-1:0]   d_wdata_i,
    output logic            d_gnt_o,
    output logic            d_rvalid_o,
    output logic [DW-1:0]   d_rdata_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [DW/8-1:0] mem_be_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [DW-1:0]   mem_rdata_i,
    output logic            busy_o,
    output logic            err_o
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_F,
        S_REQ_D,
        S_WAIT_F,
        S_WAIT_D
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      starve_q, starve_d;
    logic            f_rvalid_q, d_rvalid_q, err_q;
    logic [DW-1:0]   f_rdata_q, d_rdata_q;

    logic idle, f_win, d_win, sel_f;

    always_comb begin
        idle  = (state_q == S_IDLE);
        f_win = f_req_i && (!d_req_i || (starve_q == LIMIT));
        d_win = d_req_i && !f_win;
        // Outside IDLE the owner is locked by the state, not by the live requests.
        sel_f = idle ? f_win : ((state_q == S_REQ_F) || (state_q == S_WAIT_F));

        mem_req_o   = idle ? (f_req_i || d_req_i)
                           : ((state_q == S_REQ_F) || (state_q == S_REQ_D));
        mem_we_o    = sel_f ? 1'b0 : d_we_i;
        mem_be_o    = sel_f ? '1 : d_be_i;
        mem_addr_o  = sel_f ? f_addr_i : d_addr_i;
        mem_wdata_o = sel_f ? '0 : d_wdata_i;

        f_gnt_o = mem_gnt_i && ((idle && f_win) || (state_q == S_REQ_F));
        d_gnt_o = mem_gnt_i && ((idle && d_win) || (state_q == S_REQ_D));

        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (f_win)      state_d = mem_gnt_i ? S_WAIT_F : S_REQ_F;
                else if (d_win) state_d = mem_gnt_i ? S_WAIT_D : S_REQ_D;
            end
            S_REQ_F:  if (mem_gnt_i)    state_d = S_WAIT_F;
            S_REQ_D:  if (mem_gnt_i)    state_d = S_WAIT_D;
            S_WAIT_F: if (mem_rvalid_i) state_d = S_IDLE;
            S_WAIT_D: if (mem_rvalid_i) state_d = S_IDLE;
            default:                    state_d = S_IDLE;
        endcase

        starve_d = starve_q;
        if (!f_req_i || f_gnt_o)
            starve_d = '0;
        else if (d_gnt_o && (starve_q != LIMIT))
            starve_d = starve_q + 4'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            starve_q   <= '0;
            f_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            err_q      <= 1'b0;
            f_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            f_rvalid_q <= mem_rvalid_i && (state_q == S_WAIT_F);
            d_rvalid_q <= mem_rvalid_i && (state_q == S_WAIT_D);
            err_q      <= mem_rvalid_i && (state_q != S_WAIT_F) && (state_q != S_WAIT_D);
            if (mem_rvalid_i && (state_q == S_WAIT_F)) f_rdata_q <= mem_rdata_i;
            if (mem_rvalid_i && (state_q == S_WAIT_D)) d_rdata_q <= mem_rdata_i;
        end
    end

    assign f_rvalid_o = f_rvalid_q;
    assign f_rdata_o  = f_rdata_q;
    assign d_rvalid_o = d_rvalid_q;
    assign d_rdata_o  = d_rdata_q;
    assign err_o      = err_q;
    assign busy_o     = !idle || f_req_i || d_req_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized traffic
// checked against a transaction-level model with its own memory and requesters.
module tb_mem_port_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          f_req_i;
    logic [AW-1:0] f_addr_i;
    logic          f_gnt_o, f_rvalid_o;
    logic [DW-1:0] f_rdata_o;
    logic          d_req_i, d_we_i;
    logic [3:0]    d_be_i;
    logic [AW-1:0] d_addr_i;
    logic [DW-1:0] d_wdata_i;
    logic          d_gnt_o, d_rvalid_o;
    logic [DW-1:0] d_rdata_o;
    logic          mem_req_o, mem_we_o;
    logic [3:0]    mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_gnt_i, mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;
    logic          busy_o, err_o;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .resetn(resetn),
        .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_gnt_o(f_gnt_o),
        .f_rvalid_o(f_rvalid_o), .f_rdata_o(f_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
        .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs are driven 1 time unit after the rising edge, outputs sampled 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        f_req_i = 1'b0; f_addr_i = '0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_be_i = '0; d_addr_i = '0; d_wdata_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic test_fetch_only();
        do_reset();
        step(); // cycle 0
        f_req_i = 1'b1; f_addr_i = 32'h100; mem_gnt_i = 1'b1;
        #1;
        check("t1_f_gnt_c0", f_gnt_o, 1);
        check("t1_d_gnt_c0", d_gnt_o, 0);
        check("t1_mem_req_c0", mem_req_o, 1);
        check("t1_mem_addr", mem_addr_o, 32'h100);
        check("t1_mem_we", mem_we_o, 0);
        check("t1_mem_be", mem_be_o, 4'hF);
        check("t1_mem_wdata", mem_wdata_o, 0);
        step(); // cycle 1
        f_req_i = 1'b0; mem_gnt_i = 1'b0;
        #1;
        check("t1_mem_req_wait", mem_req_o, 0);
        check("t1_busy_wait", busy_o, 1);
        step(); // cycle 2
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        #1;
        check("t1_f_rvalid_c2", f_rvalid_o, 0);
        step(); // cycle 3
        mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        #1;
        check("t1_f_rvalid_c3", f_rvalid_o, 1);
        check("t1_f_rdata_c3", f_rdata_o, 32'hDEADBEEF);
        check("t1_d_rvalid_c3", d_rvalid_o, 0);
        check("t1_d_rdata_c3", d_rdata_o, 0);
        check("t1_err_c3", err_o, 0);
        check("t1_busy_c3", busy_o, 0);
        step(); // cycle 4
        #1;
        check("t1_f_rvalid_c4", f_rvalid_o, 0);
        check("t1_f_rdata_hold", f_rdata_o, 32'hDEADBEEF);
    endtask

    task automatic test_store_then_fetch();
        do_reset();
        step();
        f_req_i = 1'b1; f_addr_i = 32'h180;
        d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'b0011; d_addr_i = 32'h200; d_wdata_i = 32'h12345678;
        mem_gnt_i = 1'b1;
        #1;
        check("t2_d_gnt_first", d_gnt_o, 1);
        check("t2_f_gnt_first", f_gnt_o, 0);
        check("t2_mem_we", mem_we_o, 1);
        check("t2_mem_be", mem_be_o, 4'b0011);
        check("t2_mem_addr", mem_addr_o, 32'h200);
        check("t2_mem_wdata", mem_wdata_o, 32'h12345678);
        step();
        d_req_i = 1'b0;
        #1;
        check("t2_f_gnt_in_wait", f_gnt_o, 0);
        step();
        mem_rvalid_i = 1'b1;
        #1;
        step();
        mem_rvalid_i = 1'b0;
        #1;
        check("t2_store_ack", d_rvalid_o, 1);
        check("t2_f_gnt_second", f_gnt_o, 1);
        check("t2_f_addr_second", mem_addr_o, 32'h180);
        check("t2_f_we_second", mem_we_o, 0);
        step();
        f_req_i = 1'b0; mem_gnt_i = 1'b0;
        #1;
        check("t2_d_rvalid_pulse", d_rvalid_o, 0);
        step();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0BADF00D;
        #1;
        step();
        mem_rvalid_i = 1'b0;
        #1;
        check("t2_f_rvalid", f_rvalid_o, 1);
        check("t2_f_rdata", f_rdata_o, 32'h0BADF00D);
    endtask

    task automatic test_starvation();
        do_reset();
        for (int unsigned i = 0; i < 15; i++) begin
            step();
            f_req_i = 1'b1; f_addr_i = 32'h300;
            d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'hF; d_addr_i = 32'h400;
            mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0;
            #1;
            check($sformatf("t3_f_gnt_%0d", i), f_gnt_o, (i % 5) == 4);
            check($sformatf("t3_d_gnt_%0d", i), d_gnt_o, (i % 5) != 4);
            step();
            mem_rvalid_i = 1'b1; mem_rdata_i = 32'(i);
            #1;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        step();
        f_req_i = 1'b1; f_addr_i = 32'h300; mem_gnt_i = 1'b0;
        #1;
        check("t4_mem_req", mem_req_o, 1);
        check("t4_f_gnt_bp0", f_gnt_o, 0);
        for (int unsigned c = 1; c < 3; c++) begin
            step();
            d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'hF; d_addr_i = 32'h400;
            #1;
            check("t4_addr_stable", mem_addr_o, 32'h300);
            check("t4_we_stable", mem_we_o, 0);
            check("t4_d_gnt_bp", d_gnt_o, 0);
            check("t4_f_gnt_bp", f_gnt_o, 0);
        end
        step();
        mem_gnt_i = 1'b1;
        #1;
        check("t4_f_gnt_late", f_gnt_o, 1);
        check("t4_d_gnt_late", d_gnt_o, 0);
        check("t4_addr_late", mem_addr_o, 32'h300);
        step();
        f_req_i = 1'b0;
        #1;
        check("t4_d_gnt_wait", d_gnt_o, 0);
        check("t4_mem_req_wait", mem_req_o, 0);
        step();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE0001;
        #1;
        check("t4_d_gnt_rsp", d_gnt_o, 0);
        step();
        mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        #1;
        check("t4_f_rvalid", f_rvalid_o, 1);
        check("t4_f_rdata", f_rdata_o, 32'hCAFE0001);
        check("t4_d_gnt_after", d_gnt_o, 1);
        check("t4_d_addr_after", mem_addr_o, 32'h400);
        step();
        d_req_i = 1'b0; mem_gnt_i = 1'b0;
        #1;
        step();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE0002;
        #1;
        step();
        mem_rvalid_i = 1'b0;
        #1;
        check("t4_d_rvalid", d_rvalid_o, 1);
        check("t4_d_rdata", d_rdata_o, 32'hCAFE0002);
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        step();
        d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'hF; d_addr_i = 32'h500; mem_gnt_i = 1'b1;
        #1;
        step();
        d_req_i = 1'b0; mem_gnt_i = 1'b0;
        #1;
        step();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA5A5A5A5;
        #1;
        step();
        mem_rvalid_i = 1'b0;
        d_req_i = 1'b1; d_addr_i = 32'h504; mem_gnt_i = 1'b1;
        #1;
        check("t5_first_rdata", d_rdata_o, 32'hA5A5A5A5);
        check("t5_second_gnt", d_gnt_o, 1);
        step();
        d_req_i = 1'b0; mem_gnt_i = 1'b0;
        #1;
        check("t5_in_wait_busy", busy_o, 1);
        resetn = 1'b0;
        #1;
        check("t5_rst_d_rdata", d_rdata_o, 0);
        check("t5_rst_d_rvalid", d_rvalid_o, 0);
        check("t5_rst_f_rvalid", f_rvalid_o, 0);
        check("t5_rst_err", err_o, 0);
        check("t5_rst_busy", busy_o, 0);
        check("t5_rst_mem_req", mem_req_o, 0);
        step();
        resetn = 1'b1;
        step();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77777777;
        #1;
        check("t5_err_not_yet", err_o, 0);
        step();
        mem_rvalid_i = 1'b0;
        #1;
        check("t5_err_pulse", err_o, 1);
        check("t5_no_d_rvalid", d_rvalid_o, 0);
        check("t5_d_rdata_kept", d_rdata_o, 0);
        step();
        #1;
        check("t5_err_clear", err_o, 0);
    endtask

    task automatic test_spurious_idle();
        do_reset();
        step();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55555555;
        #1;
        step();
        mem_rvalid_i = 1'b0;
        f_req_i = 1'b1; f_addr_i = 32'h600; mem_gnt_i = 1'b1;
        #1;
        check("t6_err", err_o, 1);
        check("t6_f_rvalid", f_rvalid_o, 0);
        check("t6_d_rvalid", d_rvalid_o, 0);
        check("t6_still_idle_gnt", f_gnt_o, 1);
        check("t6_f_rdata", f_rdata_o, 0);
    endtask

    // Randomized traffic: each requester holds one request at a time; a tiny memory
    // answers granted requests 1..3 cycles later. Expectations come from the
    // arbitration rules applied to whole transactions.
    task automatic run_random(input int unsigned ncyc);
        logic [31:0] mem [16];
        bit          f_pend, d_pend, d_we;
        logic [3:0]  f_idx, d_idx, d_be;
        logic [31:0] d_wd;
        int unsigned streak;
        bit          txn_act, txn_d, txn_gnt;
        bit          rsp_act;
        int unsigned rsp_wait;
        logic [31:0] rsp_data, txn_exp;
        bit          txn_load;
        bit          rv_f, rv_d, rv_d_load;
        logic [31:0] exp_rv_data, last_f, last_d;
        bit          d_known, fire, want, who_d, eg_f, eg_d;
        int unsigned n_f_done, n_d_done;

        for (int unsigned i = 0; i < 16; i++) mem[i] = $urandom;
        f_pend = 0; d_pend = 0; d_we = 0; f_idx = '0; d_idx = '0; d_be = '0; d_wd = '0;
        streak = 0; txn_act = 0; txn_d = 0; txn_gnt = 0; txn_load = 0;
        rsp_act = 0; rsp_wait = 0; rsp_data = '0; txn_exp = '0;
        rv_f = 0; rv_d = 0; rv_d_load = 0; exp_rv_data = '0;
        last_f = '0; last_d = '0; d_known = 1; n_f_done = 0; n_d_done = 0;
        do_reset();

        for (int unsigned cyc = 0; cyc < ncyc; cyc++) begin
            step();
            if (!f_pend && $urandom_range(0, 1) == 1) begin
                f_pend = 1; f_idx = 4'($urandom_range(0, 15));
            end
            if (!d_pend && $urandom_range(0, 2) != 0) begin
                d_pend = 1; d_idx = 4'($urandom_range(0, 15));
                d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom_range(1, 15)); d_wd = $urandom;
            end
            f_req_i   = f_pend;
            f_addr_i  = 32'h1000 + {26'b0, f_idx, 2'b00};
            d_req_i   = d_pend;
            d_we_i    = d_we;
            d_be_i    = d_be;
            d_addr_i  = 32'h1000 + {26'b0, d_idx, 2'b00};
            d_wdata_i = d_wd;
            mem_gnt_i = ($urandom_range(0, 3) != 0);
            fire = rsp_act && (rsp_wait == 0);
            mem_rvalid_i = fire;
            mem_rdata_i  = fire ? rsp_data : $urandom;
            #1;

            check("r_f_rvalid", f_rvalid_o, rv_f);
            check("r_d_rvalid", d_rvalid_o, rv_d);
            if (rv_f) last_f = exp_rv_data;
            if (rv_d) begin
                d_known = rv_d_load;
                if (rv_d_load) last_d = exp_rv_data;
            end
            check("r_f_rdata", f_rdata_o, last_f);
            if (d_known) check("r_d_rdata", d_rdata_o, last_d);
            check("r_err", err_o, 0);
            check("r_busy", busy_o, txn_act || f_pend || d_pend);

            want = 0; who_d = 0;
            if (!txn_act) begin
                if (f_pend || d_pend) begin
                    want  = 1;
                    who_d = !(f_pend && (!d_pend || streak == LIMIT));
                end
            end else if (!txn_gnt) begin
                want = 1; who_d = txn_d;
            end
            eg_f = want && !who_d && mem_gnt_i;
            eg_d = want &&  who_d && mem_gnt_i;
            check("r_mem_req", mem_req_o, want);
            check("r_f_gnt", f_gnt_o, eg_f);
            check("r_d_gnt", d_gnt_o, eg_d);
            if (want) begin
                if (who_d) begin
                    check("r_d_addr", mem_addr_o, d_addr_i);
                    check("r_d_we", mem_we_o, d_we);
                    check("r_d_be", mem_be_o, d_be);
                    check("r_d_wdata", mem_wdata_o, d_wd);
                end else begin
                    check("r_f_addr", mem_addr_o, f_addr_i);
                    check("r_f_we", mem_we_o, 0);
                    check("r_f_be", mem_be_o, 4'hF);
                    check("r_f_wdata", mem_wdata_o, 0);
                end
            end

            rv_f = 0; rv_d = 0;
            if (fire) begin
                rv_f = !txn_d; rv_d = txn_d; rv_d_load = txn_load;
                exp_rv_data = txn_exp;
                txn_act = 0; rsp_act = 0;
                if (txn_d) n_d_done++; else n_f_done++;
            end else if (rsp_act) begin
                rsp_wait--;
            end

            if (!f_pend || eg_f) streak = 0;
            else if (eg_d && streak < LIMIT) streak++;

            if (want) begin
                txn_act = 1; txn_d = who_d; txn_gnt = 0;
                if (mem_gnt_i) begin
                    txn_gnt  = 1;
                    rsp_act  = 1;
                    rsp_wait = $urandom_range(0, 2);
                    rsp_data = mem_we_o ? $urandom : mem[mem_addr_o[5:2]];
                    if (who_d) begin
                        txn_load = !d_we;
                        txn_exp  = mem[d_idx];
                        if (d_we)
                            for (int unsigned b = 0; b < 4; b++)
                                if (d_be[b]) mem[d_idx][8*b +: 8] = d_wd[8*b +: 8];
                        d_pend = 0;
                    end else begin
                        txn_load = 1;
                        txn_exp  = mem[f_idx];
                        f_pend   = 0;
                    end
                end
            end
        end
        check("r_some_fetches_done", n_f_done > 50, 1);
        check("r_some_data_done", n_d_done > 50, 1);
    endtask

    initial begin
        resetn = 1'b0;
        idle_inputs();
        test_fetch_only();
        test_store_then_fetch();
        test_starvation();
        test_backpressure();
        test_reset_in_wait();
        test_spurious_idle();
        run_random(4000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one single-ported memory between two requesters in the five-stage core: the instruction-fetch path (IF) and the load/store path (MEM). It runs one transaction at a time and holds the selected requester until that transaction completes. Data accesses have priority, and a starvation counter guarantees forward progress for fetch. It sits between the IF/MEM stages and the shared SRAM/bus port. Its `busy_o` output can feed the hazard unit's cache-miss/stall inputs.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width; `be` width is `DW/8`.
- `STARVE_LIMIT`, 4, maximum number of consecutive data grants while fetch is pending; range 1..15.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `f_req_i`  in  1  fetch request; held with `f_addr_i` stable until `f_gnt_o`.
- `f_addr_i`  in  AW  fetch address.
- `f_gnt_o`  out  1  fetch request accepted this cycle.
- `f_rvalid_o`  out  1  fetch read data valid (1-cycle pulse).
- `f_rdata_o`  out  DW  fetch read data.
- `d_req_i`  in  1  data request; held with its payload stable until `d_gnt_o`.
- `d_we_i`  in  1  1 = store.
- `d_be_i`  in  DW/8  byte enables.
- `d_addr_i`  in  AW  data address.
- `d_wdata_i`  in  DW  store data.
- `d_gnt_o`  out  1  data request accepted.
- `d_rvalid_o`  out  1  load data valid, or store acknowledge.
- `d_rdata_o`  out  DW  load data.
- `mem_req_o`  out  1  memory request; `mem_we_o`, `mem_be_o`, `mem_addr_o`, `mem_wdata_o` qualify it.
- `mem_gnt_i`  in  1  memory accepted the request.
- `mem_rvalid_i`  in  1  memory response valid; always comes at least 1 cycle after the grant.
- `mem_rdata_i`  in  DW  memory read data.
- `busy_o`  out  1  state is not IDLE, or a request is pending.
- `err_o`  out  1  registered 1-cycle pulse when `mem_rvalid_i` is seen outside a WAIT state.

## Operation
States:
- IDLE: no owner and no outstanding transaction.
- REQ_F / REQ_D: a request to memory is presented but not yet granted; the owner is locked.
- WAIT_F / WAIT_D: the request was granted; waiting for `mem_rvalid_i`.

Winner selection in IDLE (combinational):
- Fetch wins if `f_req_i` is set and either `d_req_i` is clear or `starve_cnt == STARVE_LIMIT`.
- Otherwise data wins if `d_req_i` is set.
- `mem_req_o` and the muxed payload are driven in the same cycle.
- For a fetch, `mem_we_o` = 0, `mem_be_o` = all ones and `mem_wdata_o` = 0.

Transitions:
- IDLE → WAIT_x if the winner gets `mem_gnt_i`; otherwise IDLE → REQ_x.
- REQ_x → WAIT_x on `mem_gnt_i`.
- In REQ_x the owner never changes, even if a higher-priority request arrives.
- WAIT_x → IDLE on `mem_rvalid_i`.
- In WAIT_x, `mem_req_o` = 0.

Grants and responses:
- `x_gnt_o` = `mem_gnt_i` AND (owner == x) AND (state is IDLE or REQ_x). It is combinational.
- `x_rvalid_o` and `x_rdata_o` are registered: they are loaded from `mem_rvalid_i` and `mem_rdata_i` in WAIT_x.
- The rdata register is updated only on a valid response and holds otherwise.
- Stores also produce `d_rvalid_o`; `d_rdata_o` for a store is don't-care.

Starvation counter `starve_cnt` (4 bits):
- Increments on `d_gnt_o` while `f_req_i` = 1.
- Clears on `f_gnt_o`, and on any cycle with `f_req_i` = 0.
- Saturates at `STARVE_LIMIT`.

Boundary cases:
- A requester dropping its request while in REQ_x is a protocol violation. The arbiter keeps presenting the request until it is granted.
- Spurious `mem_rvalid_i` in IDLE or REQ_x: ignored for routing, `err_o` pulses, state is unchanged.
- Reset during REQ or WAIT: the state returns to IDLE immediately. A late `mem_rvalid_i` arriving after reset is spurious and raises `err_o`.

## Timing
- Reset values: state IDLE; `starve_cnt` 0; `f_rvalid_o`, `d_rvalid_o`, `err_o` 0; `f_rdata_o`, `d_rdata_o` 0.
- While in IDLE, the combinational outputs follow the inputs.
- With an immediate grant, a request presented in cycle 0 gets `mem_req_o` = 1 and `x_gnt_o` = 1 in cycle 0.
- If `mem_rvalid_i` arrives in cycle k, `x_rvalid_o` is high in cycle k+1, and the state is IDLE in cycle k+1.
- A new request may be issued in cycle k+1. Best-case throughput is one transaction per 2 cycles.
- No combinational path from `mem_rvalid_i` or `mem_rdata_i` to any output.

## Test plan
- Fetch only: `f_req_i` with address 0x100, `mem_gnt_i` = 1, `mem_rvalid_i` at cycle 2 with rdata 0xDEADBEEF. Expect `f_gnt_o` at cycle 0, `f_rvalid_o` at cycle 3 with `f_rdata_o` = 0xDEADBEEF, and `d_*` outputs quiet.
- Simultaneous `f_req_i` and `d_req_i` from IDLE. Expect the data request granted first, then the fetch; a store gives `d_rvalid_o` and `mem_we_o` = 1 with the correct `be`/`wdata`.
- Starvation: hold `f_req_i` and `d_req_i` continuously with `STARVE_LIMIT` = 4. Expect exactly 4 data grants, then 1 fetch grant, repeating.
- Grant backpressure: hold `mem_gnt_i` = 0 for 3 cycles on a fetch, and raise `d_req_i` during that time. Expect the owner to stay fetch (REQ_F), the payload to stay stable, and `d_gnt_o` = 0 until the fetch completes.
- Reset in WAIT_D, then `mem_rvalid_i` one cycle after reset is released. Expect all outputs at their reset values, `err_o` to pulse, and no `d_rvalid_o`.
- Spurious `mem_rvalid_i` in IDLE. Expect an `err_o` pulse, no `rvalid` to either requester, and the state to remain IDLE.
